// File: rtl/seq_gen_101_tx.sv
// seq_gen_101_tx: serial MSB-first pattern transmitter with golden overlapping-101 hit counter
module seq_gen_101_tx #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int REP_W = 8,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [HIT_W-1:0] exp_hits
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state, state_nxt;
  logic [PAT_W-1:0] pat, sh;
  logic [LEN_W-1:0] ln, idx, len_c;
  logic [REP_W-1:0] rep;
  logic [1:0] hist;
  logic accept, bit_cur, last, hit;
  always_comb begin
    len_c = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
    accept = state == IDLE && !done && start && len != '0;
    sh = pat >> idx;
    bit_cur = sh[0];
    last = idx == '0 && rep == REP_W'(1);
    hit = hist == 2'b10 && bit_cur;
    state_nxt = accept ? SEND : (state == SEND ? (last ? DONE : SEND) : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pat <= '0;
      ln <= '0;
      idx <= '0;
      rep <= '0;
      hist <= '0;
      x <= 1'b0;
      x_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      exp_hits <= '0;
    end else begin
      state <= state_nxt;
      x <= state == SEND && bit_cur;
      x_valid <= state == SEND;
      busy <= accept || state == SEND;
      done <= state == DONE;
      if (accept) begin
        pat <= pattern;
        ln <= len_c;
        idx <= len_c - 1'b1;
        rep <= (reps == '0) ? REP_W'(1) : reps;
        hist <= '0;
        exp_hits <= '0;
      end else if (state == SEND) begin
        hist <= {hist[0], bit_cur};
        exp_hits <= (hit && exp_hits != '1) ? exp_hits + 1'b1 : exp_hits;
        idx <= (idx == '0) ? ln - 1'b1 : idx - 1'b1;
        rep <= (idx == '0) ? rep - 1'b1 : rep;
      end
    end
  end
endmodule

// File: tb/tb_seq_gen_101_tx.sv
// tb_seq_gen_101_tx: randomized self-checking bench against a bit-queue reference model
module tb_seq_gen_101_tx;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, x, x_valid, busy, done;
  logic [15:0] pattern = '0;
  logic [4:0] len = '0;
  logic [7:0] reps = '0, exp_hits;
  int n_chk = 0, n_pass = 0;
  seq_gen_101_tx dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done), .exp_hits(exp_hits)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic send(input logic [15:0] p, input int l, input int r, input int abort_at);
    logic q[$];
    int le = (l > 16) ? 16 : l;
    int re = (r == 0) ? 1 : r;
    int hits = 0;
    for (int k = 0; k < re; k++)
      for (int i = le - 1; i >= 0; i--) q.push_back(p[i]);
    for (int k = 2; k < q.size(); k++)
      if (q[k-2] && !q[k-1] && q[k]) hits++;
    if (hits > 255) hits = 255;
    pattern = p;
    len = 5'(l);
    reps = 8'(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_xv", x_valid, 0);
    for (int n = 0; n < q.size(); n++) begin
      @(negedge clk);
      check("bit_xv", x_valid, 1);
      check("bit_x", x, q[n]);
      check("bit_busy", busy, 1);
      if (n == 0) begin
        start = 1'b1;
        pattern = 16'($urandom);
        len = 5'($urandom_range(1, 16));
        reps = 8'($urandom);
      end else start = 1'b0;
      if (n == abort_at) begin
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_x", x, 0);
        check("abort_xv", x_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hits", exp_hits, 0);
        @(negedge clk);
        check("abort_no_done", done, 0);
        check("abort_idle", busy, 0);
        return;
      end
    end
    @(negedge clk);
    check("done", done, 1);
    check("done_xv", x_valid, 0);
    check("done_busy", busy, 0);
    check("done_x", x, 0);
    check("done_hits", exp_hits, hits);
    start = 1'b1;
    len = 5'd3;
    @(negedge clk);
    start = 1'b0;
    check("post_done", done, 0);
    check("no_restart", busy, 0);
    check("hits_hold", exp_hits, hits);
  endtask
  task automatic zero_len;
    pattern = 16'h0005;
    len = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", busy, 0);
    @(negedge clk);
    check("len0_idle", busy, 0);
    check("len0_xv", x_valid, 0);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b1;
    len = 5'd3;
    pattern = 16'h0005;
    reps = 8'd1;
    repeat (2) begin
      @(negedge clk);
      check("rst_x", x, 0);
      check("rst_xv", x_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hits", exp_hits, 0);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("post_rst_idle", busy, 0);
    send(16'h0005, 3, 1, -1);
    send(16'h0002, 2, 3, -1);
    send(16'h0075, 8, 1, -1);
    zero_len();
    send(16'h0005, 3, 0, -1);
    send(16'h00A5, 8, 1, 1);
    send(16'hAAAA, 16, 255, -1);
    for (int t = 0; t < 25; t++) begin
      int l = int'($urandom_range(0, 20));
      if (l == 0) zero_len();
      else send(16'($urandom), l, int'($urandom_range(0, 4)), ($urandom_range(0, 5) == 0) ? 1 : -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_gen_101_tx.md
Name: seq_gen_101_tx

Overview:
Serial pattern transmitter that drives the single-bit stream consumed by the 101 sequence detectors (its x output connects to the detector's x input). A packed pattern of programmable length is loaded on a start pulse and shifted out MSB-first, one bit per clock, repeated a programmable number of times back-to-back. An internal golden counter counts overlapping "101" occurrences in the emitted stream, so a bench can check detector y pulses against an expected hit count.

Parameters:
PAT_W, 16, maximum pattern length in bits
LEN_W, 5, width of len input; must hold PAT_W
REP_W, 8, width of reps input
HIT_W, 8, width of exp_hits counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous reset, active-high
start  input  1  request to begin transmission; sampled only in IDLE
pattern  input  PAT_W  bits to send; pattern[len-1] is sent first, pattern[0] last
len  input  LEN_W  number of pattern bits to send, 1..PAT_W
reps  input  REP_W  number of back-to-back repetitions; 0 is treated as 1
x  output  1  serial data bit, registered
x_valid  output  1  x carries a pattern bit this cycle
busy  output  1  transmission in progress; start ignored
done  output  1  single-cycle pulse after the last bit
exp_hits  output  HIT_W  overlapping "101" count in the current/last stream

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- All outputs are registered.
- Reset values: x=0, x_valid=0, busy=0, done=0, exp_hits=0. The FSM is in IDLE, and the bit counter, rep counter and history are cleared.
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - Accept when start=1 and len is non-zero.
  - On acceptance, latch pattern and len. If len > PAT_W, clamp it to PAT_W.
  - Latch reps. If reps is 0, latch 1.
  - Clear exp_hits and the 2-bit history. Load bit index = len-1 and rep count = reps. Go to SEND.
  - start with len=0 is ignored and the FSM stays in IDLE.
- SEND:
  - Each cycle drives x = pattern[bit index], with x_valid=1 and busy=1.
  - Bit index decrements each cycle.
  - When bit index reaches 0 and reps remain, reload index = len-1 and decrement the rep count. There are no idle cycles between repetitions.
  - After bit 0 of the final repetition, go to DONE.
- DONE:
  - Lasts one cycle: done=1, x_valid=0, x=0, busy=0.
  - Then return to IDLE. start during DONE is ignored.
- Latency:
  - start sampled at edge k gives the first bit valid from edge k+1.
  - Exactly len*reps consecutive x_valid cycles follow.
  - done asserts for the single cycle after the last x_valid cycle.
- Golden count:
  - A 2-bit history of emitted bits is updated on every valid bit.
  - exp_hits increments when history = 10 and the current bit is 1 (overlapping detection). Detection spans repetition boundaries.
  - exp_hits is final in the DONE cycle. It holds until the next accepted start.
  - exp_hits saturates at all-ones and does not wrap.
- start while busy: ignored, and the latched parameters are unaffected. Changes to pattern/len/reps inputs mid-transmission have no effect.
- rst mid-transmission: abort at the next edge. Outputs take reset values, and no done pulse is produced.
- rst has priority over start when both are asserted in the same cycle.

Test Plan:
1. Reset: assert rst for 2 cycles with start=1 -> x=0, x_valid=0, busy=0, done=0, exp_hits=0 throughout. No transmission starts.
2. Single pattern: pattern=16'h0005, len=3, reps=1, start pulse -> x=1,0,1 on 3 consecutive x_valid cycles; done on the 4th cycle; exp_hits=1.
3. Cross-boundary overlap: pattern=16'h0002, len=2, reps=3 -> stream 1,0,1,0,1,0 with no gaps; exp_hits=2; done 7 cycles after start.
4. Long pattern: pattern=16'h0075, len=8, reps=1 -> stream 0,1,1,1,0,1,0,1; exp_hits=2.
5. Ignored requests:
   - start with len=0 -> stays IDLE, busy=0.
   - reps=0, len=3, pattern=16'h0005 -> behaves as reps=1 (3 bits, exp_hits=1).
   - start pulse mid-stream -> no restart.
6. Abort and saturation:
   - rst at the 2nd bit of a len=8 stream -> x=0, x_valid=0, busy=0 next cycle; no done.
   - pattern=16'hAAAA, len=16, reps=255 -> exp_hits saturates at 8'hFF; done after 4080 bits.
